spi_slave_i: RTL and testbench

- Receive-side SPI slave; the counterpart of the DAC SPI master (mosi/sclk/sync).
- Oversamples the three SPI lines on clk_i and deserialises MSB-first frames into a parallel word with a one-cycle valid strobe.
- Used as a DAC-side model and as the loopback checker in the measure unit; also the front end for future SPI-fed configuration registers.

---
 rtl/spi_pkg.sv | 9 +
 rtl/bit_sync.sv | 21 ++
 rtl/spi_slave_i.sv | 134 +++++++++++++
 tb/tb_spi_slave_i.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive slave.
package spi_pkg;

  typedef enum logic {IDLE, SHIFT} spi_rx_state_t;

  localparam int unsigned SPI_MIN_SYNC_STAGES = 2;
  localparam logic        SPI_SCLK_IDLE       = 1'b1;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for one asynchronous line, with configurable reset level.
module bit_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= {STAGES{RST_VAL}};
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_i.sv
// Oversampling SPI receive slave: MSB-first frames to a parallel word with vld/err strobes.
// Optional error counter (err_cnt_o, err_clr_i) enabled by SPI_SLAVE_I_ERR_CNT_EN.
module spi_slave_i
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  sclk_i,
  input  logic                  sync_i,
  input  logic                  mosi_i,
`ifdef SPI_SLAVE_I_ERR_CNT_EN
  input  logic                  err_clr_i,
  output logic [7:0]            err_cnt_o,
`endif
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  vld_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int unsigned STG = (SYNC_STAGES < SPI_MIN_SYNC_STAGES) ? SPI_MIN_SYNC_STAGES : SYNC_STAGES;
  localparam int unsigned CW  = $clog2(DATA_WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DATA_WIDTH + 1);

  logic sclk_s, sync_s, mosi_s;
  logic sclk_d, sync_d;
  logic [STG:0] arm;
  logic sclk_fall_q, sync_fall_q, sync_rise_q, mosi_q;

  spi_rx_state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic close_ok, close_bad, vld_pend, err_pend;

  bit_sync #(.STAGES(STG), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk_i), .rst(arst_i), .d(sclk_i), .q(sclk_s));
  bit_sync #(.STAGES(STG), .RST_VAL(1'b1)) u_sync_sync (.clk(clk_i), .rst(arst_i), .d(sync_i), .q(sync_s));
  bit_sync #(.STAGES(STG), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk_i), .rst(arst_i), .d(mosi_i), .q(mosi_s));

  // arm masks sync falls until both compared samples come from the real line,
  // so a sync already low at reset release is not taken as a frame start.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sclk_d      <= 1'b0;
      sync_d      <= 1'b1;
      arm         <= '0;
      sclk_fall_q <= 1'b0;
      sync_fall_q <= 1'b0;
      sync_rise_q <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sclk_d      <= sclk_s;
      sync_d      <= sync_s;
      arm         <= {arm[STG-1:0], 1'b1};
      sclk_fall_q <= (sclk_d == SPI_SCLK_IDLE) && (sclk_s != SPI_SCLK_IDLE);
      sync_fall_q <= arm[STG] && sync_d && !sync_s;
      sync_rise_q <= !sync_d && sync_s;
      mosi_q      <= mosi_s;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    cnt_nxt   = cnt;
    close_ok  = 1'b0;
    close_bad = 1'b0;
    case (state)
      IDLE: begin
        if (sync_fall_q) begin
          state_nxt = SHIFT;
          shift_nxt = '0;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (sclk_fall_q) begin
          shift_nxt = {shift[DATA_WIDTH-2:0], mosi_q};
          if (cnt != CNT_MAX) cnt_nxt = cnt + CW'(1);
        end
        // Closing uses the post-shift count so a same-cycle final bit is included.
        if (sync_rise_q) begin
          state_nxt = IDLE;
          close_ok  = (cnt_nxt == CNT_FULL);
          close_bad = (cnt_nxt != CNT_FULL);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      shift    <= '0;
      cnt      <= '0;
      data_o   <= '0;
      vld_pend <= 1'b0;
      err_pend <= 1'b0;
      vld_o    <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      shift    <= shift_nxt;
      cnt      <= cnt_nxt;
      if (close_ok) data_o <= shift_nxt;
      vld_pend <= close_ok;
      err_pend <= close_bad;
      vld_o    <= vld_pend;
      err_o    <= err_pend;
    end
  end

  assign busy_o = (state == SHIFT);

`ifdef SPI_SLAVE_I_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)                       err_cnt <= '0;
    else if (err_clr_i)               err_cnt <= '0;
    else if (err_o && err_cnt != '1)  err_cnt <= err_cnt + 8'd1;
  end

  assign err_cnt_o = err_cnt;
`endif

endmodule

// File: tb/tb_spi_slave_i.sv
// Self-checking bench for spi_slave_i: vector table, directed corner sequences, random frames.
module tb_spi_slave_i;

  logic       clk_i = 1'b0;
  logic       arst_i, sclk_i, sync_i, mosi_i;
  logic [7:0] data_o;
  logic       vld_o, err_o, busy_o;
`ifdef SPI_SLAVE_I_ERR_CNT_EN
  logic       err_clr_i;
  logic [7:0] err_cnt_o;
`endif

  spi_slave_i #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .sclk_i(sclk_i), .sync_i(sync_i), .mosi_i(mosi_i),
`ifdef SPI_SLAVE_I_ERR_CNT_EN
    .err_clr_i(err_clr_i), .err_cnt_o(err_cnt_o),
`endif
    .data_o(data_o), .vld_o(vld_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Pulse monitor, sampled 1 time unit after each active edge.
  int unsigned vld_seen = 0, err_seen = 0;
  bit both_seen = 1'b0, long_seen = 1'b0;
  logic prev_vld = 1'b0, prev_err = 1'b0;
  always @(posedge clk_i) begin
    #1;
    if (vld_o === 1'b1) vld_seen++;
    if (err_o === 1'b1) err_seen++;
    if (vld_o === 1'b1 && err_o === 1'b1) both_seen = 1'b1;
    if ((vld_o === 1'b1 && prev_vld) || (err_o === 1'b1 && prev_err)) long_seen = 1'b1;
    prev_vld = (vld_o === 1'b1);
    prev_err = (err_o === 1'b1);
  end

  task automatic wait_clk(input int unsigned k);
    repeat (k) @(negedge clk_i);
  endtask

  // Bit-bangs an n-bit MSB-first frame; leaves sync low when close is 0.
  task automatic frame(input logic [15:0] bits, input int unsigned n, input int unsigned ph, input bit close);
    sync_i = 1'b0;
    wait_clk(ph);
    for (int i = int'(n) - 1; i >= 0; i--) begin
      mosi_i = bits[i];
      wait_clk(ph);
      sclk_i = 1'b0;
      wait_clk(ph);
      sclk_i = 1'b1;
    end
    wait_clk(ph);
    if (close) begin
      sync_i = 1'b1;
      wait_clk(ph + 12);
    end
  endtask

  typedef struct {
    logic [15:0] bits;
    int unsigned n;
    logic        exp_vld;
    logic        exp_err;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t tbl[8];
  logic [7:0] model_data;
  int unsigned v0, e0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h00AA,  8, 1'b1, 1'b0, 8'hAA};
    tbl[1] = '{16'h005C,  8, 1'b1, 1'b0, 8'h5C};
    tbl[2] = '{16'h0035,  7, 1'b0, 1'b1, 8'h5C};
    tbl[3] = '{16'h0169,  9, 1'b0, 1'b1, 8'h5C};
    tbl[4] = '{16'h0081,  8, 1'b1, 1'b0, 8'h81};
    tbl[5] = '{16'h0000,  8, 1'b1, 1'b0, 8'h00};
    tbl[6] = '{16'h00FF,  8, 1'b1, 1'b0, 8'hFF};
    tbl[7] = '{16'h0001,  1, 1'b0, 1'b1, 8'hFF};

    arst_i = 1'b1; sclk_i = 1'b1; sync_i = 1'b1; mosi_i = 1'b0;
`ifdef SPI_SLAVE_I_ERR_CNT_EN
    err_clr_i = 1'b0;
`endif
    wait_clk(3);
    arst_i = 1'b0;
    wait_clk(1);
    check("rst_data", data_o, 0);
    check("rst_vld", vld_o, 0);
    check("rst_err", err_o, 0);
    check("rst_busy", busy_o, 0);
    wait_clk(10);

    for (int t = 0; t < 8; t++) begin
      v0 = vld_seen; e0 = err_seen;
      frame(tbl[t].bits, tbl[t].n, 4, 1'b1);
      check($sformatf("tbl%0d_vld", t), vld_seen - v0, {31'd0, tbl[t].exp_vld});
      check($sformatf("tbl%0d_err", t), err_seen - e0, {31'd0, tbl[t].exp_err});
      check($sformatf("tbl%0d_data", t), data_o, tbl[t].exp_data);
    end
    model_data = 8'hFF;

    // Latency: vld on the 5th sampled edge counting the capture edge as the 1st.
    v0 = vld_seen; e0 = err_seen;
    frame(16'h0081, 8, 4, 1'b0);
    check("lat_busy", busy_o, 1);
    sync_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk_i); #1;
      check($sformatf("lat_vld_k%0d", k), vld_o, (k == 5) ? 1 : 0);
      if (k == 5) check("lat_data", data_o, 8'h81);
    end
    wait_clk(12);
    check("lat_err", err_seen - e0, 0);
    model_data = 8'h81;

    // Reset in the middle of a frame.
    v0 = vld_seen; e0 = err_seen;
    frame(16'h000F, 4, 4, 1'b0);
    arst_i = 1'b1;
    wait_clk(1);
    arst_i = 1'b0;
    model_data = 8'h00;
    wait_clk(1);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_data", data_o, 0);
    wait_clk(8);
    sync_i = 1'b1;
    wait_clk(16);
    check("mid_rst_vld", vld_seen - v0, 0);
    check("mid_rst_err", err_seen - e0, 0);
    frame(16'h00F0, 8, 4, 1'b1);
    model_data = 8'hF0;
    check("after_rst_vld", vld_seen - v0, 1);
    check("after_rst_data", data_o, 8'hF0);

    // Sync held low across reset release: nothing until a real falling edge.
    sync_i = 1'b0;
    wait_clk(6);
    arst_i = 1'b1;
    wait_clk(2);
    arst_i = 1'b0;
    model_data = 8'h00;
    v0 = vld_seen; e0 = err_seen;
    wait_clk(10);
    for (int i = 0; i < 8; i++) begin
      mosi_i = i[0];
      wait_clk(4); sclk_i = 1'b0; wait_clk(4); sclk_i = 1'b1;
    end
    check("low_sync_busy", busy_o, 0);
    sync_i = 1'b1;
    wait_clk(16);
    check("low_sync_vld", vld_seen - v0, 0);
    check("low_sync_err", err_seen - e0, 0);
    check("low_sync_data", data_o, 0);
    frame(16'h003C, 8, 5, 1'b1);
    model_data = 8'h3C;
    check("low_sync_next_vld", vld_seen - v0, 1);
    check("low_sync_next_data", data_o, model_data);

    // Random frames against the frame-level model.
    for (int r = 0; r < 24; r++) begin
      logic [15:0] bits;
      int unsigned n, ph;
      bits = 16'($urandom);
      n    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 10) : 8;
      ph   = $urandom_range(4, 6);
      v0 = vld_seen; e0 = err_seen;
      frame(bits, n, ph, 1'b1);
      if (n == 8) model_data = bits[7:0];
      check($sformatf("rnd%0d_vld", r), vld_seen - v0, (n == 8) ? 1 : 0);
      check($sformatf("rnd%0d_err", r), err_seen - e0, (n == 8) ? 0 : 1);
      check($sformatf("rnd%0d_data", r), data_o, model_data);
    end

`ifdef SPI_SLAVE_I_ERR_CNT_EN
    begin
      bit found;
      err_clr_i = 1'b1;
      wait_clk(1);
      err_clr_i = 1'b0;
      wait_clk(1);
      check("cnt_clear", err_cnt_o, 0);
      for (int s = 0; s < 3; s++) frame(16'h0005, 3, 4, 1'b1);
      check("cnt_three", err_cnt_o, 3);
      frame(16'h0015, 5, 4, 1'b0);
      sync_i = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        @(posedge clk_i); #1;
        if (err_o === 1'b1) begin
          err_clr_i = 1'b1;
          @(posedge clk_i); #1;
          err_clr_i = 1'b0;
          found = 1'b1;
        end
      end
      check("cnt_err_seen", found, 1);
      check("cnt_clr_priority", err_cnt_o, 0);
      wait_clk(10);
    end
`endif

    check("pulse_exclusive", both_seen, 0);
    check("pulse_one_cycle", long_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
